// File: rtl/mips_multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback for one instruction at a time.
module mips_multicycle_controller #(
  parameter logic [1:0] EXC_VECTOR_SEL = 2'b11
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       ZF,
  input  logic       OF,
  input  logic       BF,
  output logic [3:0] ALU_Cntrl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] PCSrc,
  output logic       PC_En,
  output logic       Exception,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11,
    S_EXCEPT  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t state_q, state_d;

  function automatic logic [3:0] alu_sel(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001: alu_sel = 4'b0010;
      6'b100010, 6'b100011: alu_sel = 4'b0110;
      6'b100100: alu_sel = 4'b0000;
      6'b100101: alu_sel = 4'b0001;
      6'b100110: alu_sel = 4'b0011;
      6'b100111: alu_sel = 4'b0100;
      6'b101010: alu_sel = 4'b0111;
      6'b101011: alu_sel = 4'b0101;
      6'b000000: alu_sel = 4'b1000;
      6'b000010: alu_sel = 4'b1010;
      6'b000011: alu_sel = 4'b1100;
      6'b000100: alu_sel = 4'b1001;
      6'b000110: alu_sel = 4'b1011;
      6'b000111: alu_sel = 4'b1101;
      default:   alu_sel = 4'b1111;
    endcase
  endfunction

  logic signed_trap;
  assign signed_trap = OF & ((Funct == 6'b100000) | (Funct == 6'b100010));

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    ALU_Cntrl = ALU_ADD;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    PCSrc     = 2'b00;
    PC_En     = 1'b0;
    Exception = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PC_En   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADR;
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDI_EX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_EXCEPT;
        endcase
      end
      S_MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA   = 1'b1;
        ALU_Cntrl = alu_sel(Funct);
        state_d   = (BF | signed_trap) ? S_EXCEPT : S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALU_Cntrl = ALU_SUB;
        PCSrc     = 2'b01;
        PC_En     = ((Opcode == OP_BEQ) & ZF) | ((Opcode == OP_BNE) & ~ZF);
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = OF ? S_EXCEPT : S_ADDI_WB;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        PC_En = 1'b1;
      end
      S_EXCEPT: begin
        Exception = 1'b1;
        PCSrc     = EXC_VECTOR_SEL;
        PC_En     = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // No strobe may escape while reset is held, even before the first edge.
    if (!RST) begin
      ALU_Cntrl = ALU_ADD;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      IorD      = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      PCSrc     = 2'b00;
      PC_En     = 1'b0;
      Exception = 1'b0;
    end
  end

  assign State = RST ? state_q : 4'd0;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for mips_multicycle_controller.
// Directed vector table, reset corner cases and random instructions.
module tb_mips_multicycle_controller;

  logic       CLK, RST;
  logic [5:0] Opcode, Funct;
  logic       ZF, OF, BF;
  logic [3:0] ALU_Cntrl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic [1:0] PCSrc;
  logic       PC_En, Exception;
  logic [3:0] State;

  mips_multicycle_controller #(.EXC_VECTOR_SEL(2'b11)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct),
    .ZF(ZF), .OF(OF), .BF(BF), .ALU_Cntrl(ALU_Cntrl),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCSrc(PCSrc),
    .PC_En(PC_En), .Exception(Exception), .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       iord, memw, irw, regdst, mtr, regw;
    logic [1:0] pcsrc;
    logic       pcen, exc;
  } out_t;

  typedef struct {
    string       name;
    logic [5:0]  op, fn;
    logic        zf, of, bf;
    logic [19:0] path;
    int          n;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [3:0] alu_ref(input logic [5:0] f);
    logic [3:0] r;
    r = 4'b1111;
    if (f == 6'h20 || f == 6'h21) r = 4'b0010;
    if (f == 6'h22 || f == 6'h23) r = 4'b0110;
    if (f == 6'h24) r = 4'b0000;
    if (f == 6'h25) r = 4'b0001;
    if (f == 6'h26) r = 4'b0011;
    if (f == 6'h27) r = 4'b0100;
    if (f == 6'h2A) r = 4'b0111;
    if (f == 6'h2B) r = 4'b0101;
    if (f == 6'h00) r = 4'b1000;
    if (f == 6'h02) r = 4'b1010;
    if (f == 6'h03) r = 4'b1100;
    if (f == 6'h04) r = 4'b1001;
    if (f == 6'h06) r = 4'b1011;
    if (f == 6'h07) r = 4'b1101;
    return r;
  endfunction

  function automatic out_t reset_out();
    out_t o;
    o = '0;
    o.alu = 4'b0010;
    return o;
  endfunction

  function automatic out_t exp_out(input int s, input logic [5:0] op,
                                   input logic [5:0] fn, input logic zf);
    out_t o;
    o = reset_out();
    o.st = 4'(s);
    case (s)
      0:  begin o.irw = 1; o.srcb = 2'b01; o.pcen = 1; end
      1:  o.srcb = 2'b11;
      2:  begin o.srca = 1; o.srcb = 2'b10; end
      3:  o.iord = 1;
      4:  begin o.regw = 1; o.mtr = 1; end
      5:  begin o.iord = 1; o.memw = 1; end
      6:  begin o.srca = 1; o.alu = alu_ref(fn); end
      7:  begin o.regw = 1; o.regdst = 1; end
      8:  begin
        o.srca = 1; o.alu = 4'b0110; o.pcsrc = 2'b01;
        o.pcen = (op == 6'b000100 && zf) || (op == 6'b000101 && !zf);
      end
      9:  begin o.srca = 1; o.srcb = 2'b10; end
      10: o.regw = 1;
      11: begin o.pcsrc = 2'b10; o.pcen = 1; end
      12: begin o.exc = 1; o.pcsrc = 2'b11; o.pcen = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Instruction-level model: which steps an instruction walks through.
  function automatic void ref_path(input logic [5:0] op, input logic [5:0] fn,
                                   input logic of, input logic bf,
                                   output logic [19:0] p, output int n);
    int q[$];
    q = '{0, 1};
    if (op == 6'b100011) q = '{0, 1, 2, 3, 4};
    else if (op == 6'b101011) q = '{0, 1, 2, 5};
    else if (op == 6'b000000) begin
      q.push_back(6);
      if (bf || (of && (fn == 6'h20 || fn == 6'h22))) q.push_back(12);
      else q.push_back(7);
    end
    else if (op == 6'b000100 || op == 6'b000101) q.push_back(8);
    else if (op == 6'b001000) begin
      q.push_back(9);
      q.push_back(of ? 12 : 10);
    end
    else if (op == 6'b000010) q.push_back(11);
    else q.push_back(12);
    p = '0;
    n = q.size();
    for (int i = 0; i < n; i++) p[4*i +: 4] = 4'(q[i]);
  endfunction

  task automatic check(input string name, input out_t e);
    out_t g;
    g = {State, ALU_Cntrl, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite,
         RegDst, MemtoReg, RegWrite, PCSrc, PC_En, Exception};
    n_total++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got %h expected %h (st %0d vs %0d)",
                  name, g, e, g.st, e.st);
  endtask

  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic zf,
                           input logic of, input logic bf,
                           input logic [19:0] p, input int n);
    Opcode = op; Funct = fn; ZF = zf; OF = of; BF = bf;
    for (int i = 0; i < n; i++) begin
      #1 check(name, exp_out(int'(p[4*i +: 4]), op, fn, zf));
      @(negedge CLK);
    end
    #1 check({name, "_next_fetch"}, exp_out(0, op, fn, zf));
  endtask

  function automatic vec_t v(string nm, logic [5:0] op, logic [5:0] fn,
                             logic zf, logic of, logic bf,
                             logic [19:0] p, int n);
    vec_t r;
    r.name = nm; r.op = op; r.fn = fn;
    r.zf = zf; r.of = of; r.bf = bf;
    r.path = p; r.n = n;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [5:0] legal_fn[16];
    logic [5:0] ops[7];
    logic [19:0] rp;
    int rn;
    logic [5:0] op, fn;
    logic zf, of, bf;

    legal_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b000101, 6'b001000, 6'b000010};

    tbl.push_back(v("lw",        6'b100011, 6'h00, 0, 0, 0, 20'h43210, 5));
    tbl.push_back(v("sw",        6'b101011, 6'h00, 0, 0, 0, 20'h05210, 4));
    tbl.push_back(v("sub_ok",    6'b000000, 6'h22, 0, 0, 0, 20'h07610, 4));
    tbl.push_back(v("sub_trap",  6'b000000, 6'h22, 0, 1, 0, 20'h0C610, 4));
    tbl.push_back(v("subu_of",   6'b000000, 6'h23, 0, 1, 0, 20'h07610, 4));
    tbl.push_back(v("add_trap",  6'b000000, 6'h20, 0, 1, 0, 20'h0C610, 4));
    tbl.push_back(v("addu_of",   6'b000000, 6'h21, 0, 1, 0, 20'h07610, 4));
    tbl.push_back(v("bad_fn",    6'b000000, 6'h3F, 0, 0, 1, 20'h0C610, 4));
    tbl.push_back(v("bad_fn_nb", 6'b000000, 6'h3F, 0, 0, 0, 20'h07610, 4));
    tbl.push_back(v("beq_t",     6'b000100, 6'h00, 1, 0, 0, 20'h00810, 3));
    tbl.push_back(v("beq_nt",    6'b000100, 6'h00, 0, 0, 0, 20'h00810, 3));
    tbl.push_back(v("bne_t",     6'b000101, 6'h00, 0, 0, 0, 20'h00810, 3));
    tbl.push_back(v("bne_nt",    6'b000101, 6'h00, 1, 0, 0, 20'h00810, 3));
    tbl.push_back(v("addi",      6'b001000, 6'h00, 0, 0, 0, 20'h0A910, 4));
    tbl.push_back(v("addi_trap", 6'b001000, 6'h00, 0, 1, 0, 20'h0C910, 4));
    tbl.push_back(v("j",         6'b000010, 6'h00, 0, 0, 0, 20'h00B10, 3));
    tbl.push_back(v("illegal",   6'b111111, 6'h00, 0, 0, 0, 20'h00C10, 3));
    foreach (legal_fn[i])
      tbl.push_back(v($sformatf("fn_%02h", legal_fn[i]), 6'b000000,
                      legal_fn[i], 0, 0, 0, 20'h07610, 4));

    RST = 1'b0; Opcode = 6'b101011; Funct = 6'h20;
    ZF = 1'b1; OF = 1'b1; BF = 1'b1;
    #1 check("reset_pre_edge", reset_out());
    repeat (3) @(negedge CLK);
    #1 check("reset_held", reset_out());
    RST = 1'b1;

    foreach (tbl[i])
      run_instr(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].zf,
                tbl[i].of, tbl[i].bf, tbl[i].path, tbl[i].n);

    // Abort a store in MEM_WR: no write strobe while reset is low.
    Opcode = 6'b101011; Funct = 6'h00; ZF = 0; OF = 0; BF = 0;
    #1 check("abort_fetch", exp_out(0, Opcode, Funct, 0));
    @(negedge CLK);
    #1 check("abort_decode", exp_out(1, Opcode, Funct, 0));
    @(negedge CLK);
    #1 check("abort_memadr", exp_out(2, Opcode, Funct, 0));
    @(negedge CLK);
    #1 check("abort_memwr", exp_out(5, Opcode, Funct, 0));
    RST = 1'b0;
    #1 check("abort_rst_low", reset_out());
    @(negedge CLK);
    #1 check("abort_rst_held", reset_out());
    RST = 1'b1;
    ref_path(6'b100011, 6'h00, 0, 0, rp, rn);
    run_instr("lw_after_abort", 6'b100011, 6'h00, 0, 0, 0, rp, rn);

    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 15)];
      zf = 1'($urandom);
      of = ($urandom_range(0, 3) == 0);
      bf = ($urandom_range(0, 7) == 0);
      ref_path(op, fn, of, bf, rp, rn);
      run_instr($sformatf("rand%0d_op%02h_fn%02h", k, op, fn),
                op, fn, zf, of, bf, rp, rn);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Main control FSM of the multi-cycle MIPS core. Decodes the instruction register's opcode and funct fields and sequences every datapath step: fetch, decode, execute, memory, writeback. Drives the shared ALU's 4-bit operation select and consumes its ZF/OF/BF flags to resolve branches and raise exceptions. One instruction is in flight at a time. All datapath registers sit outside this block.

## Interface
Parameters:
- EXC_VECTOR_SEL, 2'b11: PCSrc code that selects the exception vector.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset.
- Opcode  in  6  IR[31:26]; stable from the cycle after FETCH.
- Funct  in  6  IR[5:0].
- ZF  in  1  ALU zero flag.
- OF  in  1  ALU signed-overflow flag.
- BF  in  1  ALU bad-function flag.
- ALU_Cntrl  out  4  ALU operation select.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  register write address: 0 = rt, 1 = rd.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- PC_En  out  1  PC load enable (unconditional write, or branch condition true).
- Exception  out  1  one-cycle pulse on a trap.
- State  out  4  current state code (for debug).

## Operation
- States and codes: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXECUTE 6, ALU_WB 7, BRANCH 8, ADDI_EX 9, ADDI_WB 10, JUMP 11, EXCEPT 12. Codes 13-15 go to FETCH.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU_Cntrl=ADD(0010), PCSrc=00, PC_En=1. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD. The branch target is computed here. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADR.
  - 000000 (R-type) -> EXECUTE.
  - 000100 (beq) or 000101 (bne) -> BRANCH.
  - 001000 (addi) -> ADDI_EX.
  - 000010 (j) -> JUMP.
  - any other opcode -> EXCEPT.
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, ADD. lw goes to MEM_RD; sw goes to MEM_WR.
- MEM_RD: IorD=1, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, then FETCH.
- MEM_WR: IorD=1, MemWrite=1, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU_Cntrl from Funct:
  - add/addu 100000/100001 -> 0010; sub/subu 100010/100011 -> 0110.
  - and 100100 -> 0000; or 100101 -> 0001; xor 100110 -> 0011; nor 100111 -> 0100.
  - slt 101010 -> 0111; sltu 101011 -> 0101.
  - sll 000000 -> 1000; srl 000010 -> 1010; sra 000011 -> 1100.
  - sllv 000100 -> 1001; srlv 000110 -> 1011; srav 000111 -> 1101.
  - any other funct -> 1111.
- EXECUTE exit: go to EXCEPT if BF=1, or if OF=1 and Funct is 100000 or 100010. addu/subu never trap. Otherwise go to ALU_WB.
- ALU_WB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB(0110), PCSrc=01. PC_En = (beq & ZF) | (bne & ~ZF). Then FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ADD. OF=1 goes to EXCEPT; otherwise ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, then FETCH.
- JUMP: PCSrc=10, PC_En=1, then FETCH.
- EXCEPT: Exception=1, PCSrc=EXC_VECTOR_SEL, PC_En=1, RegWrite=0, MemWrite=0, then FETCH. The faulting result is never written back.
- Default value of every output in every state not listed above: 0. ALU_Cntrl defaults to 0010.

## Timing
- Outputs are Moore-decoded from the state register. The exceptions are PC_En in BRANCH (depends on ZF) and ALU_Cntrl in EXECUTE (depends on Funct); both are combinational on inputs that are stable in that state.
- Flags are sampled on the clock edge that leaves EXECUTE, BRANCH or ADDI_EX.
- Cycles per instruction: lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; trapping R-type or addi 4; illegal opcode 3.
- Reset: while RST=0 at a clock edge, the state becomes FETCH. While RST is low, all outputs are forced to 0 (ALU_Cntrl=0010, State=0).
  - The first FETCH strobes (IRWrite, PC_En) occur in the first cycle with RST=1.
- Reset asserted mid-instruction aborts it. No write strobe may be issued in the cycle RST is low.

## Test plan
- Reset, then lw (Opcode 100011): State runs 0,1,2,3,4,0. RegWrite=1 with MemtoReg=1 only in state 4. IRWrite=1 only in state 0.
- R-type sub (Funct 100010) with OF=0: ALU_Cntrl=0110 in EXECUTE, then ALU_WB with RegDst=1. With OF=1: EXCEPT, Exception pulses once, PCSrc=11, no RegWrite. Repeat with subu (100011) and OF=1: no trap.
- beq with ZF=1 -> PC_En=1 and PCSrc=01 in BRANCH. With ZF=0 -> PC_En=0. bne inverts both cases.
- Sweep all 16 legal funct codes -> ALU_Cntrl matches the table. Funct 111111 with BF=1 -> EXCEPT.
- Opcode 111111 -> DECODE goes to EXCEPT in 3 cycles. j -> PC_En=1, PCSrc=10 in JUMP.
- RST=0 asserted in MEM_WR -> MemWrite=0 that cycle. State=0 next. Normal fetch after release.
